alu_pipe: RTL and testbench

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pipe.sv | 149 ++++++++++++++
 tb/tb_alu_pipe.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with a valid/ready handshake on both sides.
// S1 registers the operands; S2 holds the computed result and flags.
module alu_pipe #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic [3:0]           ALU_FUN,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY,
    output logic [2*WIDTH-1:0]   ALU_OUT,
    output logic                 CARRY,
    output logic                 OVF,
    output logic                 ZERO,
    output logic                 DIV0,
    output logic [15:0]          OP_CNT
);

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_MUL  = 4'h2,
        OP_DIV  = 4'h3,
        OP_AND  = 4'h4,
        OP_OR   = 4'h5,
        OP_NAND = 4'h6,
        OP_NOR  = 4'h7,
        OP_XOR  = 4'h8,
        OP_XNOR = 4'h9,
        OP_EQ   = 4'hA,
        OP_GT   = 4'hB,
        OP_LT   = 4'hC,
        OP_SHR  = 4'hD,
        OP_SHL  = 4'hE,
        OP_PASS = 4'hF
    } op_e;

    logic               s1_valid;
    logic [WIDTH-1:0]   s1_a;
    logic [WIDTH-1:0]   s1_b;
    op_e                s1_fun;

    logic               s1_en;
    logic               s2_en;

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] res;
    logic               res_carry;
    logic               res_ovf;
    logic               res_div0;

    assign s2_en    = !OUT_VALID || OUT_READY;
    assign s1_en    = !s1_valid || s2_en;
    // Gated by reset so no beat looks accepted while the pipe is held clear.
    assign IN_READY = s1_en && RST;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_fun   <= OP_ADD;
        end else if (s1_en) begin
            s1_valid <= IN_VALID;
            if (IN_VALID) begin
                s1_a   <= A;
                s1_b   <= B;
                s1_fun <= op_e'(ALU_FUN);
            end
        end
    end

    always_comb begin
        sum       = {1'b0, s1_a} + {1'b0, s1_b};
        diff      = {1'b0, s1_a} - {1'b0, s1_b};
        res       = '0;
        res_carry = 1'b0;
        res_ovf   = 1'b0;
        res_div0  = 1'b0;
        case (s1_fun)
            OP_ADD: begin
                res       = {{(WIDTH-1){1'b0}}, sum};
                res_carry = sum[WIDTH];
                res_ovf   = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) && (sum[WIDTH-1] != s1_a[WIDTH-1]);
            end
            OP_SUB: begin
                res       = {{WIDTH{1'b0}}, diff[WIDTH-1:0]};
                res_carry = diff[WIDTH];
                res_ovf   = (s1_a[WIDTH-1] != s1_b[WIDTH-1]) && (diff[WIDTH-1] != s1_a[WIDTH-1]);
            end
            OP_MUL:  res = {{WIDTH{1'b0}}, s1_a} * {{WIDTH{1'b0}}, s1_b};
            OP_DIV: begin
                if (s1_b == '0) begin
                    res      = {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
                    res_div0 = 1'b1;
                end else begin
                    res = {{WIDTH{1'b0}}, s1_a / s1_b};
                end
            end
            OP_AND:  res = {{WIDTH{1'b0}}, s1_a & s1_b};
            OP_OR:   res = {{WIDTH{1'b0}}, s1_a | s1_b};
            OP_NAND: res = {{WIDTH{1'b0}}, ~(s1_a & s1_b)};
            OP_NOR:  res = {{WIDTH{1'b0}}, ~(s1_a | s1_b)};
            OP_XOR:  res = {{WIDTH{1'b0}}, s1_a ^ s1_b};
            OP_XNOR: res = {{WIDTH{1'b0}}, ~(s1_a ^ s1_b)};
            OP_EQ:   res = {{(2*WIDTH-1){1'b0}}, s1_a == s1_b};
            OP_GT:   res = {{(2*WIDTH-1){1'b0}}, s1_a > s1_b};
            OP_LT:   res = {{(2*WIDTH-1){1'b0}}, s1_a < s1_b};
            OP_SHR:  res = {{WIDTH{1'b0}}, s1_a >> 1};
            OP_SHL:  res = {{(WIDTH-1){1'b0}}, s1_a, 1'b0};
            OP_PASS: res = {{WIDTH{1'b0}}, s1_a};
            default: res = '0;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            OUT_VALID <= 1'b0;
            ALU_OUT   <= '0;
            CARRY     <= 1'b0;
            OVF       <= 1'b0;
            ZERO      <= 1'b0;
            DIV0      <= 1'b0;
        end else if (s2_en) begin
            OUT_VALID <= s1_valid;
            if (s1_valid) begin
                ALU_OUT <= res;
                CARRY   <= res_carry;
                OVF     <= res_ovf;
                ZERO    <= (res == '0);
                DIV0    <= res_div0;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            OP_CNT <= '0;
        end else if (OUT_VALID && OUT_READY) begin
            OP_CNT <= OP_CNT + 16'd1;
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe at WIDTH=8.
module tb_alu_pipe;

    logic        CLK;
    logic        RST;
    logic        IN_VALID;
    logic        IN_READY;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [3:0]  ALU_FUN;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [15:0] ALU_OUT;
    logic        CARRY;
    logic        OVF;
    logic        ZERO;
    logic        DIV0;
    logic [15:0] OP_CNT;

    int checks = 0;
    int errors = 0;

    alu_pipe #(.WIDTH(8)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .A         (A),
        .B         (B),
        .ALU_FUN   (ALU_FUN),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .ALU_OUT   (ALU_OUT),
        .CARRY     (CARRY),
        .OVF       (OVF),
        .ZERO      (ZERO),
        .DIV0      (DIV0),
        .OP_CNT    (OP_CNT)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Drives one op with OUT_READY high; returns on the negedge where its result is visible.
    task automatic issue_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] fun);
        @(negedge CLK);
        A = a; B = b; ALU_FUN = fun; IN_VALID = 1'b1; OUT_READY = 1'b1;
        @(negedge CLK);
        IN_VALID = 1'b0;
        @(negedge CLK);
    endtask

    task automatic do_reset;
        @(negedge CLK);
        IN_VALID = 1'b0; OUT_READY = 1'b1; RST = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
    endtask

    task automatic test_reset;
        RST = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b1; A = '0; B = '0; ALU_FUN = '0;
        #2 RST = 1'b0;
        @(negedge CLK);
        checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", OUT_VALID); end
        checks++; if (ALU_OUT !== 16'h0000) begin errors++; $display("FAIL rst_alu_out got %h exp 0000", ALU_OUT); end
        checks++; if ({CARRY, OVF, ZERO, DIV0} !== 4'b0000) begin errors++; $display("FAIL rst_flags got %b exp 0000", {CARRY, OVF, ZERO, DIV0}); end
        checks++; if (OP_CNT !== 16'h0000) begin errors++; $display("FAIL rst_op_cnt got %h exp 0000", OP_CNT); end
        checks++; if (IN_READY !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b exp 0", IN_READY); end
        RST = 1'b1;
        #1;
        checks++; if (IN_READY !== 1'b1) begin errors++; $display("FAIL rel_in_ready got %b exp 1", IN_READY); end
    endtask

    task automatic test_add;
        @(negedge CLK);
        A = 8'hFF; B = 8'h01; ALU_FUN = 4'h0; IN_VALID = 1'b1; OUT_READY = 1'b1;
        #1;
        checks++; if (IN_READY !== 1'b1) begin errors++; $display("FAIL add_in_ready got %b exp 1", IN_READY); end
        @(negedge CLK);
        IN_VALID = 1'b0;
        checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL add_early_valid got %b exp 0", OUT_VALID); end
        @(negedge CLK);
        checks++; if (OUT_VALID !== 1'b1) begin errors++; $display("FAIL add_latency got %b exp 1", OUT_VALID); end
        checks++; if (ALU_OUT !== 16'h0100) begin errors++; $display("FAIL add_ff_01 got %h exp 0100", ALU_OUT); end
        checks++; if ({CARRY, OVF, ZERO, DIV0} !== 4'b1000) begin errors++; $display("FAIL add_ff_01_flags got %b exp 1000", {CARRY, OVF, ZERO, DIV0}); end
        issue_op(8'h7F, 8'h01, 4'h0);
        checks++; if (ALU_OUT !== 16'h0080) begin errors++; $display("FAIL add_7f_01 got %h exp 0080", ALU_OUT); end
        checks++; if ({CARRY, OVF} !== 2'b01) begin errors++; $display("FAIL add_7f_01_flags got %b exp 01", {CARRY, OVF}); end
        issue_op(8'h80, 8'h80, 4'h0);
        checks++; if (ALU_OUT !== 16'h0100) begin errors++; $display("FAIL add_80_80 got %h exp 0100", ALU_OUT); end
        checks++; if ({CARRY, OVF} !== 2'b11) begin errors++; $display("FAIL add_80_80_flags got %b exp 11", {CARRY, OVF}); end
    endtask

    task automatic test_sub;
        issue_op(8'h7F, 8'h80, 4'h1);
        checks++; if (ALU_OUT !== 16'h00FF) begin errors++; $display("FAIL sub_7f_80 got %h exp 00ff", ALU_OUT); end
        checks++; if ({CARRY, OVF, ZERO} !== 3'b110) begin errors++; $display("FAIL sub_7f_80_flags got %b exp 110", {CARRY, OVF, ZERO}); end
        issue_op(8'h05, 8'h05, 4'h1);
        checks++; if (ALU_OUT !== 16'h0000) begin errors++; $display("FAIL sub_5_5 got %h exp 0000", ALU_OUT); end
        checks++; if ({CARRY, OVF, ZERO} !== 3'b001) begin errors++; $display("FAIL sub_5_5_flags got %b exp 001", {CARRY, OVF, ZERO}); end
    endtask

    task automatic test_muldiv;
        issue_op(8'hFF, 8'hFF, 4'h2);
        checks++; if (ALU_OUT !== 16'hFE01) begin errors++; $display("FAIL mul_ff_ff got %h exp fe01", ALU_OUT); end
        checks++; if ({CARRY, DIV0} !== 2'b00) begin errors++; $display("FAIL mul_flags got %b exp 00", {CARRY, DIV0}); end
        issue_op(8'h64, 8'h00, 4'h3);
        checks++; if (ALU_OUT !== 16'h00FF) begin errors++; $display("FAIL div_by0 got %h exp 00ff", ALU_OUT); end
        checks++; if (DIV0 !== 1'b1) begin errors++; $display("FAIL div_by0_flag got %b exp 1", DIV0); end
        issue_op(8'h64, 8'h07, 4'h3);
        checks++; if (ALU_OUT !== 16'h000E) begin errors++; $display("FAIL div_64_7 got %h exp 000e", ALU_OUT); end
        checks++; if (DIV0 !== 1'b0) begin errors++; $display("FAIL div_64_7_flag got %b exp 0", DIV0); end
    endtask

    task automatic test_logic;
        logic [7:0]  la [12];
        logic [7:0]  lb [12];
        logic [3:0]  lf [12];
        logic [15:0] le [12];
        logic        lz [12];
        la = '{8'hF0, 8'h0F, 8'hF0, 8'h0F, 8'hFF, 8'hAA, 8'h07, 8'h05, 8'h05, 8'h81, 8'h81, 8'hA5};
        lb = '{8'h3C, 8'h30, 8'h3C, 8'h30, 8'h0F, 8'h0F, 8'h07, 8'h03, 8'h03, 8'h00, 8'h00, 8'h00};
        lf = '{4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
        le = '{16'h0030, 16'h003F, 16'h00CF, 16'h00C0, 16'h00F0, 16'h005A,
               16'h0001, 16'h0001, 16'h0000, 16'h0040, 16'h0102, 16'h00A5};
        lz = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 12; i++) begin
            issue_op(la[i], lb[i], lf[i]);
            checks++;
            if (ALU_OUT !== le[i]) begin
                errors++; $display("FAIL logic_op%0h got %h exp %h", lf[i], ALU_OUT, le[i]);
            end
            checks++;
            if ({CARRY, OVF, ZERO, DIV0} !== {3'b000, lz[i]} << 1) begin
                errors++; $display("FAIL logic_op%0h_flags got %b exp %b", lf[i], {CARRY, OVF, ZERO, DIV0}, {3'b000, lz[i]} << 1);
            end
        end
    endtask

    task automatic test_backpressure;
        logic [7:0]  ta [8];
        logic [7:0]  tb [8];
        logic [3:0]  tf [8];
        logic [15:0] te [8];
        logic        tc [8];
        logic [31:0] pat;
        int          tx;
        int          rx;
        int          inflight;
        logic        prev_stall;
        logic        exp_ready;
        ta = '{8'h10, 8'h03, 8'h10, 8'hC8, 8'h55, 8'hFF, 8'h09, 8'h3C};
        tb = '{8'h20, 8'h05, 8'h10, 8'h0A, 8'hFF, 8'h00, 8'h08, 8'h00};
        tf = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h8, 4'hE, 4'hA, 4'hF};
        te = '{16'h0030, 16'h00FE, 16'h0100, 16'h0014, 16'h00AA, 16'h01FE, 16'h0000, 16'h003C};
        tc = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        pat = 32'hF3A5_C6E0;
        do_reset;
        tx = 0; rx = 0; inflight = 0; prev_stall = 1'b0;
        for (int cyc = 0; cyc < 200 && rx < 8; cyc++) begin
            @(negedge CLK);
            if (prev_stall) begin
                checks++;
                if (OUT_VALID !== 1'b1) begin errors++; $display("FAIL bp_stall_hold cyc %0d got %b exp 1", cyc, OUT_VALID); end
            end
            if (OUT_VALID === 1'b1) begin
                checks++;
                if (rx >= 8) begin
                    errors++; $display("FAIL bp_extra_result got %h exp none", ALU_OUT);
                end else if (ALU_OUT !== te[rx] || CARRY !== tc[rx]) begin
                    errors++; $display("FAIL bp_result%0d got %h/%b exp %h/%b", rx, ALU_OUT, CARRY, te[rx], tc[rx]);
                end
            end
            OUT_READY = pat[cyc % 32];
            IN_VALID  = (tx < 8);
            if (tx < 8) begin
                A = ta[tx]; B = tb[tx]; ALU_FUN = tf[tx];
            end
            #1;
            exp_ready = !(inflight == 2 && !OUT_READY);
            checks++;
            if (IN_READY !== exp_ready) begin
                errors++; $display("FAIL bp_in_ready cyc %0d got %b exp %b", cyc, IN_READY, exp_ready);
            end
            if (IN_VALID && IN_READY) begin tx++; inflight++; end
            if (OUT_VALID && OUT_READY) begin rx++; inflight--; end
            prev_stall = OUT_VALID && !OUT_READY;
        end
        IN_VALID = 1'b0;
        checks++; if (rx != 8) begin errors++; $display("FAIL bp_complete got %0d exp 8", rx); end
        @(negedge CLK);
        checks++; if (OP_CNT !== 16'd8) begin errors++; $display("FAIL bp_op_cnt got %0d exp 8", OP_CNT); end
        checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL bp_drained got %b exp 0", OUT_VALID); end
    endtask

    task automatic test_reset_midflight;
        @(negedge CLK);
        OUT_READY = 1'b0; A = 8'h01; B = 8'h02; ALU_FUN = 4'h0; IN_VALID = 1'b1;
        @(negedge CLK);
        A = 8'h03; B = 8'h04;
        @(negedge CLK);
        IN_VALID = 1'b0;
        checks++; if (OUT_VALID !== 1'b1 || ALU_OUT !== 16'h0003) begin errors++; $display("FAIL mid_inflight got %b/%h exp 1/0003", OUT_VALID, ALU_OUT); end
        #2 RST = 1'b0;
        #1;
        checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b exp 0", OUT_VALID); end
        checks++; if (OP_CNT !== 16'h0000) begin errors++; $display("FAIL mid_rst_op_cnt got %h exp 0000", OP_CNT); end
        checks++; if (ALU_OUT !== 16'h0000) begin errors++; $display("FAIL mid_rst_alu_out got %h exp 0000", ALU_OUT); end
        checks++; if (IN_READY !== 1'b0) begin errors++; $display("FAIL mid_rst_in_ready got %b exp 0", IN_READY); end
        @(negedge CLK);
        RST = 1'b1; OUT_READY = 1'b1; A = 8'h20; B = 8'h03; ALU_FUN = 4'h1; IN_VALID = 1'b1;
        #1;
        checks++; if (IN_READY !== 1'b1) begin errors++; $display("FAIL mid_first_accept got %b exp 1", IN_READY); end
        @(negedge CLK);
        IN_VALID = 1'b0;
        checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL mid_stale got %b exp 0", OUT_VALID); end
        @(negedge CLK);
        checks++; if (OUT_VALID !== 1'b1 || ALU_OUT !== 16'h001D) begin errors++; $display("FAIL mid_new_result got %b/%h exp 1/001d", OUT_VALID, ALU_OUT); end
        @(negedge CLK);
        checks++; if (OUT_VALID !== 1'b0 || OP_CNT !== 16'd1) begin errors++; $display("FAIL mid_after got %b/%0d exp 0/1", OUT_VALID, OP_CNT); end
    endtask

    task automatic test_counter_wrap;
        int sent;
        int cons;
        do_reset;
        sent = 0; cons = 0;
        ALU_FUN = 4'hF; B = 8'h00; OUT_READY = 1'b1;
        for (int cyc = 0; cyc < 70000 && cons < 65536; cyc++) begin
            @(negedge CLK);
            if (OUT_VALID === 1'b1) begin
                if (cons == 65535) begin
                    checks++;
                    if (OP_CNT !== 16'hFFFF) begin errors++; $display("FAIL wrap_pre got %h exp ffff", OP_CNT); end
                end
                cons++;
            end
            IN_VALID = (sent < 65536);
            A = 8'(sent);
            if (sent < 65536) sent++;
        end
        IN_VALID = 1'b0;
        checks++; if (cons != 65536) begin errors++; $display("FAIL wrap_consumed got %0d exp 65536", cons); end
        @(negedge CLK);
        checks++; if (OP_CNT !== 16'h0000) begin errors++; $display("FAIL wrap_op_cnt got %h exp 0000", OP_CNT); end
        checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL wrap_drained got %b exp 0", OUT_VALID); end
    endtask

    initial begin
        test_reset;
        test_add;
        test_sub;
        test_muldiv;
        test_logic;
        test_backpressure;
        test_reset_midflight;
        test_counter_wrap;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
